// File: rtl/add_accumulator_pkg.sv
// Shared widths and FSM encoding for the nibble-serial accumulator.
package add_accumulator_pkg;

    localparam int OP_W  = 4;
    localparam int ACC_W = 8;
    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ADD_LO = 2'd1,
        ST_ADD_HI = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/add_accumulator_four_bit_adder.sv
// Plain 4-bit ripple adder with carry in/out; the only adder in the accumulator.
module four_bit_adder (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       cin_i,
    output logic [3:0] sum_o,
    output logic       cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {4'b0000, cin_i};

endmodule

// File: rtl/add_accumulator.sv
// Frame accumulator: sums N_OPS 4-bit operands into an 8-bit register using one
// 4-bit adder shared between a low-nibble pass and a high-nibble pass.
module add_accumulator
    import add_accumulator_pkg::*;
#(
    parameter int N_OPS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic             out_ovf
);

    localparam logic [CNT_W-1:0] N_OPS_C = CNT_W'(N_OPS);

    state_e           state_q;
    logic [ACC_W-1:0] acc_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             carry_q;
    logic [OP_W-1:0]  opnd_q;
    logic             ovf_q;

    logic [3:0] add_a;
    logic [3:0] add_b;
    logic       add_cin;
    logic [3:0] add_sum;
    logic       add_cout;

    // High pass adds only the stored carry to the upper nibble.
    always_comb begin
        add_a   = acc_q[3:0];
        add_b   = opnd_q;
        add_cin = 1'b0;
        if (state_q == ST_ADD_HI) begin
            add_a   = acc_q[7:4];
            add_b   = 4'b0000;
            add_cin = carry_q;
        end
    end

    four_bit_adder u_adder (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o (add_cout)
    );

    assign cnt_d = cnt_q + 8'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ACCEPT;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            opnd_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (clear) begin
            state_q <= ST_ACCEPT;
            acc_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_ACCEPT: begin
                    if (in_valid) begin
                        opnd_q  <= in_data;
                        state_q <= ST_ADD_LO;
                    end
                end
                ST_ADD_LO: begin
                    acc_q[3:0] <= add_sum;
                    carry_q    <= add_cout;
                    state_q    <= ST_ADD_HI;
                end
                ST_ADD_HI: begin
                    acc_q[7:4] <= add_sum;
                    // Carry out of the top nibble means the frame sum passed 255.
                    if (add_cout) begin
                        ovf_q <= 1'b1;
                    end
                    cnt_q   <= cnt_d;
                    state_q <= (cnt_d == N_OPS_C) ? ST_DONE : ST_ACCEPT;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        ovf_q   <= 1'b0;
                        state_q <= ST_ACCEPT;
                    end
                end
                default: state_q <= ST_ACCEPT;
            endcase
        end
    end

    assign in_ready  = (state_q == ST_ACCEPT);
    assign out_valid = (state_q == ST_DONE);
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

endmodule
